// File: rtl/bsg_front_side_bus_hop_in_fc.sv
// FSB hop input stage with flow control: buffers upstream packets and
// releases the head only after the forward and (if matched) local ports take it.
module bsg_front_side_bus_hop_in_fc #(
    parameter int width_p = 32,
    parameter int els_p = 2,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [2*width_p-1:0]   data_o,
    output logic [1:0]             v_o,
    input  logic [1:0]             yumi_i,
    input  logic                   local_accept_i
);

    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
        $error("els_p must be a power of two and at least 2");
    end

    logic [width_p-1:0]   mem [els_p];
    logic [lg_els_lp-1:0] wptr;
    logic [lg_els_lp-1:0] rptr;
    logic [lg_els_lp:0]   count;
    logic [lg_els_lp:0]   count_next;
    logic [1:0]           sent;
    logic                 full;
    logic                 empty;
    logic                 enq;
    logic                 deq;
    logic                 done0;
    logic                 done1;

    assign full    = (count == (lg_els_lp+1)'(els_p));
    assign empty   = (count == '0);
    assign ready_o = ~full & reset_n_i;
    assign enq     = v_i & ready_o;

    assign data_o = {mem[rptr], mem[rptr]};
    assign v_o[0] = ~empty & ~sent[0];
    assign v_o[1] = ~empty & local_accept_i & ~sent[1];

    // A non-local head needs nothing from channel 1.
    assign done0 = sent[0] | yumi_i[0];
    assign done1 = sent[1] | yumi_i[1] | ~local_accept_i;
    assign deq   = ~empty & done0 & done1;

    assign count_next = count
                      + (lg_els_lp+1)'(enq)
                      - (lg_els_lp+1)'(deq);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            sent  <= 2'b00;
        end else begin
            count <= count_next;
            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
                sent <= 2'b00;
            end else begin
                sent <= sent | (yumi_i & v_o);
            end
        end
    end

`ifndef SYNTHESIS
    a_yumi_legal : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (yumi_i & ~v_o) == 2'b00
    ) else $error("yumi_i asserted on a channel without v_o");

    a_accept_stable : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (!empty && sent == 2'b01) |-> $stable(local_accept_i)
    ) else $error("local_accept_i changed during partial delivery");
`endif

endmodule
